// File: rtl/prog_div_pkg.sv
// prog_div_pkg: shared width limits and count-direction encoding for the programmable divider.
package prog_div_pkg;
    localparam int WIDTH_DEF = 8;
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;
    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;
endpackage

// File: rtl/prog_div_next.sv
// prog_div_next: terminal-count compare and next-count selection (load > enable > hold).
module prog_div_next
    import prog_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] modulus,
    input  logic [WIDTH-1:0] load_value,
    input  logic             up,
    input  logic             enable,
    input  logic             load,
    output logic [WIDTH-1:0] q_d,
    output logic             tc
);
    logic dir_up;
    logic at_top;
    logic at_zero;
    always_comb begin
        dir_up  = (dir_e'(up) == DIR_UP);
        at_top  = (q >= modulus);
        at_zero = (q == '0);
        // an out-of-range value wraps to zero without flagging terminal count
        tc      = enable & ~load & (dir_up ? (q == modulus) : at_zero);
        q_d     = load    ? load_value :
                  !enable ? q :
                  dir_up  ? (at_top ? '0 : q + 1'b1) :
                            (at_zero ? modulus : q - 1'b1);
    end
endmodule

// File: rtl/prog_div_counter.sv
// prog_div_counter: programmable up/down modulus counter with terminal-count pulse.
// Define PROG_DIV_SQUARE_EN to get a div_out square wave toggling on each terminal count.
module prog_div_counter
    import prog_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             clear_b,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] modulus,
    input  logic             up,
    output logic [WIDTH-1:0] q_out,
    output logic             tc,
    output logic             div_out
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             tc_raw;

    prog_div_next #(.WIDTH(WIDTH)) u_next (
        .q          (q_q),
        .modulus    (modulus),
        .load_value (load_value),
        .up         (up),
        .enable     (enable),
        .load       (load),
        .q_d        (q_d),
        .tc         (tc_raw)
    );

    always_ff @(posedge clock or negedge clear_b) begin
        if (!clear_b) q_q <= '0;
        else          q_q <= q_d;
    end

    // q_out is zero in reset, so tc must be masked or modulus==0 would flag it
    assign q_out = q_q;
    assign tc    = tc_raw & clear_b;

`ifdef PROG_DIV_SQUARE_EN
    logic div_q;
    logic div_d;
    always_comb div_d = div_q ^ tc;
    always_ff @(posedge clock or negedge clear_b) begin
        if (!clear_b) div_q <= 1'b0;
        else          div_q <= div_d;
    end
    assign div_out = div_q;
`else
    assign div_out = 1'b0;
`endif
endmodule

// File: tb/tb_prog_div_counter.sv
// tb_prog_div_counter: table-driven vectors plus reset, up, down and square-wave sequences at WIDTH=4.
module tb_prog_div_counter;
    typedef struct packed {
        logic       ld;
        logic       en;
        logic       up;
        logic [3:0] lv;
        logic [3:0] md;
        logic       tc;
        logic [3:0] q;
    } vec_t;

    logic       clock;
    logic       clear_b;
    logic       enable;
    logic       load;
    logic [3:0] load_value;
    logic [3:0] modulus;
    logic       up;
    logic [3:0] q_out;
    logic       tc;
    logic       div_out;

    int errors = 0;
    int checks = 0;
    vec_t v[17];

    prog_div_counter #(.WIDTH(4)) dut (
        .clock      (clock),
        .clear_b    (clear_b),
        .enable     (enable),
        .load       (load),
        .load_value (load_value),
        .modulus    (modulus),
        .up         (up),
        .q_out      (q_out),
        .tc         (tc),
        .div_out    (div_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic vec_t mk(int ld, int en, int u, int lv, int md, int t, int q);
        vec_t r;
        r.ld = ld[0];
        r.en = en[0];
        r.up = u[0];
        r.lv = lv[3:0];
        r.md = md[3:0];
        r.tc = t[0];
        r.q  = q[3:0];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        int dn_q[7];
        dn_q = '{5, 4, 3, 2, 1, 0, 5};
        v[0]  = mk(1, 1, 1, 3, 9, 0, 3);
        v[1]  = mk(0, 1, 1, 0, 9, 0, 4);
        v[2]  = mk(1, 0, 1, 9, 9, 0, 9);
        v[3]  = mk(0, 1, 1, 0, 9, 1, 0);
        v[4]  = mk(1, 0, 1, 12, 9, 0, 12);
        v[5]  = mk(0, 1, 1, 0, 9, 0, 0);
        v[6]  = mk(0, 0, 1, 0, 9, 0, 0);
        v[7]  = mk(0, 1, 0, 0, 5, 1, 5);
        v[8]  = mk(0, 1, 0, 0, 5, 0, 4);
        v[9]  = mk(1, 1, 0, 12, 5, 0, 12);
        v[10] = mk(0, 1, 0, 0, 5, 0, 11);
        v[11] = mk(0, 1, 1, 0, 0, 0, 0);
        v[12] = mk(0, 1, 1, 0, 0, 1, 0);
        v[13] = mk(0, 1, 1, 0, 0, 1, 0);
        v[14] = mk(0, 1, 1, 0, 7, 0, 1);
        v[15] = mk(0, 1, 0, 0, 7, 0, 0);
        v[16] = mk(0, 0, 0, 0, 7, 0, 0);

        clear_b = 1'b0; enable = 1'b0; load = 1'b0; load_value = '0; modulus = '0; up = 1'b1;
        #12;
        chk("reset_q", q_out, 0);
        chk("reset_tc", tc, 0);
        chk("reset_div", div_out, 0);
        @(negedge clock);
        clear_b = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clock);
            load = v[i].ld; enable = v[i].en; up = v[i].up;
            load_value = v[i].lv; modulus = v[i].md;
            #1 chk($sformatf("vec%0d_tc", i), tc, v[i].tc);
            @(posedge clock);
            #1 chk($sformatf("vec%0d_q", i), q_out, v[i].q);
        end

        @(negedge clock);
        load = 1'b1; load_value = 4'd0; enable = 1'b0; up = 1'b1; modulus = 4'd9;
        @(negedge clock);
        load = 1'b0; enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1 chk($sformatf("up%0d_q", i), q_out, i % 10);
            chk($sformatf("up%0d_tc", i), tc, (i % 10) == 9);
            @(negedge clock);
        end

        load = 1'b1; load_value = 4'd5; enable = 1'b0; up = 1'b0; modulus = 4'd5;
        @(negedge clock);
        load = 1'b0; enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            #1 chk($sformatf("dn%0d_q", i), q_out, dn_q[i]);
            chk($sformatf("dn%0d_tc", i), tc, i == 5);
            @(negedge clock);
        end

        load = 1'b1; load_value = 4'd7; enable = 1'b0; up = 1'b1; modulus = 4'd9;
        @(negedge clock);
        load = 1'b0; enable = 1'b1;
        #2 clear_b = 1'b0;
        #1 chk("async_clr_q", q_out, 0);
        chk("async_clr_tc", tc, 0);
        chk("async_clr_div", div_out, 0);
        modulus = 4'd0;
        #1 chk("clr_tc_mod0", tc, 0);
        load = 1'b1; load_value = 4'd5;
        @(posedge clock);
        #1 chk("clr_load_drop", q_out, 0);
        @(negedge clock);
        load = 1'b0; modulus = 4'd9; clear_b = 1'b1;
        @(posedge clock);
        #1 chk("no_recovery", q_out, 1);

        @(negedge clock);
        clear_b = 1'b0;
        #1 chk("sq_reset_div", div_out, 0);
        @(negedge clock);
        clear_b = 1'b1; load = 1'b0; enable = 1'b1; up = 1'b1; modulus = 4'd3;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clock);
`ifdef PROG_DIV_SQUARE_EN
            #1 chk($sformatf("sq%0d_div", k), div_out, (k / 4) % 2);
`else
            #1 chk($sformatf("sq%0d_div", k), div_out, 0);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
